// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared ids, FSM encoding and defaults for the cache port arbiter
package cache_arb_pkg;
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_REFILL = 1'b1;
   localparam logic [0:0] ST_ARB = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam int DEFAULT_MAX_BURST = 8;
endpackage

// File: rtl/cache_port_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant; the pointer moves to the loser after each transfer
module rr_arbiter2
   import cache_arb_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_valid,
   input  logic       i_update,
   input  logic       i_winner,
   output logic       o_grant,
   output logic       o_any
);
   logic rr_ptr;
   always_comb begin
      o_grant = &i_valid ? rr_ptr : i_valid[1];
      o_any = |i_valid;
   end
   always_ff @(posedge i_clk)
      rr_ptr <= i_reset ? REQ_CPU : i_update ? ~i_winner : rr_ptr;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares cache RAM port A between CPU and refill with locked bursts and 1-cycle response routing
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req0_valid,
   output logic                  o_req0_ready,
   input  logic                  i_req0_write,
   input  logic                  i_req0_lock,
   input  logic [ADDR_WIDTH-1:0] i_req0_addr,
   input  logic [DATA_WIDTH-1:0] i_req0_data,
   output logic                  o_rsp0_valid,
   output logic [DATA_WIDTH-1:0] o_rsp0_data,
   input  logic                  i_req1_valid,
   output logic                  o_req1_ready,
   input  logic                  i_req1_write,
   input  logic                  i_req1_lock,
   input  logic [ADDR_WIDTH-1:0] i_req1_addr,
   input  logic [DATA_WIDTH-1:0] i_req1_data,
   output logic                  o_rsp1_valid,
   output logic [DATA_WIDTH-1:0] o_rsp1_data,
   output logic                  o_ram_request,
   output logic                  o_ram_write,
   output logic [ADDR_WIDTH-1:0] o_ram_address,
   output logic [DATA_WIDTH-1:0] o_ram_data,
   input  logic [DATA_WIDTH-1:0] i_ram_data,
   input  logic                  i_ram_data_DV
);
   logic [0:0] state;
   logic owner, tag_valid, tag_id;
   logic [7:0] lock_cnt, next_cnt;
   logic grant, any, winner, xfer, locked, stay_locked, w_write, w_lock;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [1:0] valid;
   assign valid = {i_req1_valid, i_req0_valid};
   rr_arbiter2 u_rr (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_valid(valid),
      .i_update(xfer),
      .i_winner(winner),
      .o_grant(grant),
      .o_any(any)
   );
   always_comb begin
      locked = state == ST_LOCKED;
      winner = locked ? owner : grant;
      xfer = !i_reset && (locked ? valid[owner] : any);
      w_write = winner ? i_req1_write : i_req0_write;
      w_lock = winner ? i_req1_lock : i_req0_lock;
      w_addr = winner ? i_req1_addr : i_req0_addr;
      w_data = winner ? i_req1_data : i_req0_data;
      next_cnt = locked ? lock_cnt + 8'd1 : 8'd1;
      stay_locked = w_lock && next_cnt < 8'(MAX_BURST);
      o_req0_ready = xfer && winner == REQ_CPU;
      o_req1_ready = xfer && winner == REQ_REFILL;
      o_ram_request = xfer;
      o_ram_write = xfer && w_write;
      o_ram_address = xfer ? w_addr : '0;
      o_ram_data = xfer ? w_data : '0;
      o_rsp0_valid = !i_reset && tag_valid && tag_id == REQ_CPU && i_ram_data_DV;
      o_rsp1_valid = !i_reset && tag_valid && tag_id == REQ_REFILL && i_ram_data_DV;
      o_rsp0_data = i_reset ? '0 : i_ram_data;
      o_rsp1_data = i_reset ? '0 : i_ram_data;
   end
   // Hitting MAX_BURST (including 1 on the first transfer) drops straight back to ARB
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_ARB;
         owner <= REQ_CPU;
         lock_cnt <= 8'd0;
         tag_valid <= 1'b0;
         tag_id <= REQ_CPU;
      end else begin
         tag_valid <= xfer;
         tag_id <= winner;
         if (xfer) begin
            state <= stay_locked ? ST_LOCKED : ST_ARB;
            owner <= winner;
            lock_cnt <= stay_locked ? next_cnt : 8'd0;
         end
      end
   end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares port A (read/write) of the cache dual-port RAM between two requesters: 0 = CPU-side cache logic, 1 = refill/DMA engine.
- Provides a valid/ready request handshake per requester, round-robin arbitration, and optional locked bursts.
- Routes each 1-cycle-latency RAM response back to the requester that issued it.
- Port B (read-only) is untouched and stays wired directly.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- MAX_BURST, 8, maximum transfers per lock before a forced release; range 1..255.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has a request
- o_req0_ready  out  1  requester 0 request accepted this cycle
- i_req0_write  in  1  1 = write, 0 = read
- i_req0_lock  in  1  keep grant after this transfer
- i_req0_addr  in  ADDR_WIDTH  address
- i_req0_data  in  DATA_WIDTH  write data
- o_rsp0_valid  out  1  response for requester 0
- o_rsp0_data  out  DATA_WIDTH  read data, or echoed write data
- i_req1_*, o_req1_ready, o_rsp1_*  same set as above for requester 1
- o_ram_request  out  1  to RAM i_request
- o_ram_write  out  1  to RAM i_write
- o_ram_address  out  ADDR_WIDTH  to RAM i_address
- o_ram_data  out  DATA_WIDTH  to RAM i_data
- i_ram_data  in  DATA_WIDTH  from RAM o_data
- i_ram_data_DV  in  1  from RAM o_data_DV

Behaviour:
- Transfer definition: a transfer occurs on a cycle where reqN_valid && reqN_ready. At most one transfer per cycle.
- Ready generation:
  - o_reqN_ready is combinational from valids and registered state.
  - A requester must hold valid and its fields stable until ready.
- RAM drive:
  - RAM outputs are a combinational mux of the winner's fields.
  - o_ram_request = 1 exactly on transfer cycles; o_ram_write/address/data = 0 when no transfer.
- Response routing:
  - On a transfer, register tag_valid = 1 and tag_id = winner; otherwise tag_valid = 0.
  - Next cycle: o_rspN_valid = tag_valid && tag_id == N && i_ram_data_DV.
  - o_rspN_data = i_ram_data for both N (data is qualified by valid only).
  - Request-to-response latency is exactly 1 cycle.
  - A DV pulse arriving with tag_valid = 0 is ignored.
- State machine:
  - ARB (idle/arbitrate):
    - Only one valid: that requester wins.
    - Both valid: the requester indicated by rr_ptr wins.
    - On every transfer, rr_ptr <= ~winner.
    - Transfer with lock = 1: go to LOCKED(owner = winner), lock_cnt <= 1.
  - LOCKED:
    - Only the owner can get ready; the other requester's ready = 0 even when the owner's valid = 0. Owner idle gaps keep the lock.
    - Owner transfer with lock = 0: return to ARB.
    - Owner transfer with lock = 1: lock_cnt++. If lock_cnt reaches MAX_BURST on that transfer, force return to ARB; that transfer is still performed.
    - On exit, rr_ptr points to the non-owner, so a waiting requester wins next.
  - MAX_BURST = 1: a lock request degenerates to a single-transfer grant, never entering LOCKED.
- Counter: lock_cnt width is 8 bits.
- Reset (synchronous; applies on any cycle, including mid-burst or with a response in flight):
  - State = ARB, rr_ptr = 0, lock_cnt = 0, tag_valid = 0.
  - All ready, rsp_valid, rsp_data and ram_* outputs = 0 while i_reset is high.
  - A response pending at reset is dropped: no rsp_valid in the cycle after reset deasserts.
- Simultaneous events:
  - A new request is accepted in the same cycle a prior response is delivered, so back-to-back transfers give one response per cycle.
  - Requester switching is zero-bubble.
- Write responses: the RAM echoes write data with DV. The arbiter forwards it as a response, so requesters see one rsp per transfer.

Decomposition:
- Shared package cache_arb_pkg:
  - requester-id constants REQ_CPU = 0, REQ_REFILL = 1;
  - state encoding ARB/LOCKED;
  - default MAX_BURST.
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with rr_ptr update. It can be reused by later L2 sharing.
- The lock FSM and response tagging stay in the top module.

Test Plan:
- Single reader: req0 read addr 0x005 (after a prior write of 0xA5) -> ready0 same cycle, o_ram_request=1, rsp0_valid with data 0xA5 one cycle later, rsp1_valid stays 0.
- Contention: both valid continuously from reset, reads to 0x010 and 0x020 -> grants alternate 0,1,0,1; each rsp routed to the correct id; one transfer per cycle, no bubbles.
- Locked burst, MAX_BURST=4: req1 with lock=1 on 6 consecutive writes while req0 is valid -> req1 gets 4 transfers, forced release, req0 wins next cycle, then req1 resumes.
- Lock with owner gap: req0 lock=1 transfer, then req0 valid low for 3 cycles while req1 valid -> ready1 stays 0; req0 transfer with lock=0 releases, req1 granted the following cycle.
- Reset mid-operation: assert i_reset in the cycle after a req0 read transfer, during a locked burst -> no rsp0_valid; after release state = ARB and rr_ptr = 0 (req0 wins a tie).
- Spurious DV: force i_ram_data_DV=1 with no prior transfer -> both rsp_valid remain 0.
